// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter feeding a downstream bit-serial consumer.
// MSB first, gated by a bit-rate strobe, with gapless back-to-back word reload.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             bit_en,
    output logic             sout,
    output logic             sout_valid
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign last_bit   = (state == SHIFT) && (cnt == LAST) && bit_en;
    // A new word may only enter while idle or as the last bit leaves.
    assign load_ready = !rst && ((state == IDLE) || last_bit);
    assign sout       = (state == SHIFT) && shreg[WIDTH-1];
    assign sout_valid = (state == SHIFT) && bit_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (load_valid && load_ready) begin
            state <= SHIFT;
            shreg <= din;
            cnt   <= '0;
        end else if ((state == SHIFT) && bit_en) begin
            if (cnt == LAST) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
                cnt   <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed vector table, corner
// sequences and a randomized run, all compared to a bit-queue reference model.
module tb_piso_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         load_valid = 1'b0;
    logic         bit_en = 1'b1;
    logic         load_ready, sout, sout_valid;

    int nchecks = 0;
    int nerr = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(load_ready), .bit_en(bit_en), .sout(sout), .sout_valid(sout_valid)
    );

    always #5 clk = ~clk;

    // Reference: the bits of the word in flight, front = bit on the wire.
    bit q[$];

    typedef struct {
        logic         r, lv, be;
        logic [W-1:0] d;
        logic         er, es, ev;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare at negedge against the model, then
    // advance the model across the following rising edge.
    task automatic cyc(input logic r, lv, be, input logic [W-1:0] d,
                       output logic ar, as, av);
        bit active, e_ready, e_sout, e_sv;
        rst = r; load_valid = lv; bit_en = be; din = d;
        @(negedge clk);
        active  = (q.size() != 0);
        e_ready = !r && (!active || (q.size() == 1 && be));
        e_sout  = active ? q[0] : 1'b0;
        e_sv    = active && be;
        ar = load_ready; as = sout; av = sout_valid;
        chk("mdl_load_ready", {31'd0, load_ready}, {31'd0, e_ready});
        chk("mdl_sout", {31'd0, sout}, {31'd0, e_sout});
        chk("mdl_sout_valid", {31'd0, sout_valid}, {31'd0, e_sv});
        @(posedge clk);
        if (r) q.delete();
        else if (lv && e_ready) begin
            q.delete();
            for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
        end else if (active && be) void'(q.pop_front());
        #1;
    endtask

    initial begin
        vec_t         tbl[13];
        logic         ar, as, av;
        logic [3:0]   sh4;
        logic [15:0]  det, word16, rdy16;
        logic [W-1:0] word;
        int           nb, nv;
        logic [W-1:0] b66;

        // Reset for 2 edges, then a lone 8'h66 word at full bit rate.
        b66 = 8'h66;
        tbl[0] = '{1, 0, 1, 8'h00, 0, 0, 0};
        tbl[1] = '{1, 0, 1, 8'h00, 0, 0, 0};
        tbl[2] = '{0, 0, 1, 8'h00, 1, 0, 0};
        tbl[3] = '{0, 1, 1, 8'h66, 1, 0, 0};
        for (int i = 0; i < 8; i++)
            tbl[4+i] = '{0, 0, 1, 8'h00, (i == 7), b66[7-i], 1};
        tbl[12] = '{0, 0, 1, 8'h00, 1, 0, 0};

        sh4 = '0; det = '0; nb = 0;
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].r, tbl[i].lv, tbl[i].be, tbl[i].d, ar, as, av);
            chk($sformatf("tbl%0d_ready", i), {31'd0, ar}, {31'd0, tbl[i].er});
            chk($sformatf("tbl%0d_sout", i), {31'd0, as}, {31'd0, tbl[i].es});
            chk($sformatf("tbl%0d_valid", i), {31'd0, av}, {31'd0, tbl[i].ev});
            if (av === 1'b1) begin
                sh4 = {sh4[2:0], as}; nb++;
                if (nb >= 4 && sh4 == 4'b0110) det[nb] = 1'b1;
            end
        end
        chk("det0110_positions", {16'd0, det}, 32'h0110);

        // Back-to-back A5 then 3C with load_valid held high.
        cyc(0, 1, 1, 8'hA5, ar, as, av);
        word16 = '0; rdy16 = '0; nv = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, (i < 8), 1, 8'h3C, ar, as, av);
            word16 = {word16[14:0], as}; rdy16[i] = ar;
            if (av === 1'b1) nv++;
        end
        chk("b2b_bits", {16'd0, word16}, 32'hA53C);
        chk("b2b_valid_cnt", nv, 16);
        chk("b2b_ready_mask", {16'd0, rdy16}, 32'h8080);

        // Half-rate bit_en: each bit shown for 2 cycles, word done in 16.
        cyc(0, 1, 1, 8'hF0, ar, as, av);
        word = '0; nv = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, (i % 2 == 1), 8'h00, ar, as, av);
            if (av === 1'b1) begin word = {word[W-2:0], as}; nv++; end
        end
        chk("half_valid_cnt", nv, 8);
        chk("half_bits", {24'd0, word}, 32'hF0);
        cyc(0, 0, 0, 8'h00, ar, as, av);
        chk("half_idle_ready", {31'd0, ar}, 32'd1);

        // Mid-word offer of FF must be ignored.
        cyc(0, 1, 1, 8'h66, ar, as, av);
        word = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, (i == 2 || i == 3), 1, 8'hFF, ar, as, av);
            if (i == 2 || i == 3) chk("midword_ready", {31'd0, ar}, 32'd0);
            word = {word[W-2:0], as};
        end
        chk("midword_bits", {24'd0, word}, 32'h66);

        // Reset after the 3rd bit of 66, then a fresh 0F word.
        cyc(0, 1, 1, 8'h66, ar, as, av);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h00, ar, as, av);
        cyc(1, 1, 1, 8'hAA, ar, as, av);
        chk("rst_mid_ready", {31'd0, ar}, 32'd0);
        cyc(1, 0, 1, 8'h00, ar, as, av);
        chk("rst_mid_sout", {31'd0, as}, 32'd0);
        chk("rst_mid_valid", {31'd0, av}, 32'd0);
        cyc(0, 1, 1, 8'h0F, ar, as, av);
        chk("rst_rel_ready", {31'd0, ar}, 32'd1);
        word = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 8'h00, ar, as, av);
            word = {word[W-2:0], as};
        end
        chk("rst_reload_bits", {24'd0, word}, 32'h0F);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++)
            cyc(($urandom_range(63) == 0), ($urandom_range(1) == 1),
                ($urandom_range(3) != 0), W'($urandom), ar, as, av);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: the number of bits per parallel word (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port din, input, WIDTH bits: the parallel word to serialize, sampled only on an accepted load.
REQ-005 The block SHALL have port load_valid, input, 1 bit: the upstream word-offer strobe.
REQ-006 The block SHALL have port load_ready, output, 1 bit: high when a word offered this cycle is accepted at the next edge.
REQ-007 The block SHALL have port bit_en, input, 1 bit: the bit-rate strobe; one serial bit is consumed per cycle with bit_en=1 (tie to 1 for one bit per clk).
REQ-008 The block SHALL have port sout, output, 1 bit: the serial bit, MSB first; it drives the x input of the downstream sequence detector.
REQ-009 The block SHALL have port sout_valid, output, 1 bit: high in each cycle in which sout carries a bit being consumed.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-011 The block SHALL hold a WIDTH-bit shift register shreg and a bit counter cnt of width clog2(WIDTH), counting 0..WIDTH-1.
REQ-012 load_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when cnt==WIDTH-1 and bit_en=1; otherwise 0.
REQ-013 A load SHALL be accepted when load_valid=1 and load_ready=1 at a rising edge: shreg<=din, cnt<=0, state<=SHIFT.
REQ-014 When load_valid=1 and load_ready=0, the offer SHALL be ignored with no state change; din is not captured.
REQ-015 sout SHALL equal shreg[WIDTH-1] in SHIFT and 0 in IDLE.
REQ-016 sout_valid SHALL equal (state==SHIFT) and bit_en.
REQ-017 In SHIFT with bit_en=1 and cnt<WIDTH-1, at the edge: shreg shifts left by one (LSB filled with 0) and cnt increments.
REQ-018 In SHIFT with bit_en=0: shreg, cnt and state SHALL hold, and sout SHALL hold the current bit.
REQ-019 In SHIFT with bit_en=1 and cnt==WIDTH-1 (last bit), at the edge: if a load is accepted, apply REQ-013 (gapless back-to-back); else state<=IDLE, cnt<=0.
REQ-020 Latency: for a word accepted at edge N with bit_en held at 1, bit i (MSB=bit 0) SHALL appear on sout with sout_valid=1 in the cycle following edge N+i.
REQ-021 Back-to-back words with bit_en held at 1 SHALL produce a continuous sout_valid=1 stream with no idle cycle between words.
REQ-022 A load SHALL never be accepted mid-word (cnt<WIDTH-1 in SHIFT).

Reset
REQ-023 While rst=1 at a rising edge, state<=IDLE, shreg<=0 and cnt<=0, overriding any load or shift in that cycle.
REQ-024 While rst=1, load_ready SHALL be forced to 0; sout and sout_valid SHALL be 0 from the edge at which reset is applied.
REQ-025 Reset asserted mid-word SHALL discard the remaining bits; after rst is deasserted the block is IDLE with load_ready=1.
REQ-026 No output SHALL go to X after the first reset edge.

Verification
REQ-027 The bench SHALL cover: rst=1 for 2 edges, then release -> load_ready=1, sout=0, sout_valid=0.
REQ-028 The bench SHALL cover: WIDTH=8, bit_en=1, single load of din=8'h66 -> sout sequence 0,1,1,0,0,1,1,0 over 8 cycles, then IDLE; the downstream 0110 detector asserts after the 4th and 8th bits.
REQ-029 The bench SHALL cover: two words 8'hA5 then 8'h3C, load_valid held at 1 -> 16 consecutive sout_valid=1 cycles, bits 10100101 00111100, load_ready=1 only on the last-bit cycles.
REQ-030 The bench SHALL cover: bit_en=1 on alternate cycles with din=8'hF0 -> each bit is held for 2 cycles, sout_valid is high 8 times, and the word completes in 16 cycles.
REQ-031 The bench SHALL cover: load_valid=1 with din=8'hFF while mid-word -> ignored, and the current word completes unchanged.
REQ-032 The bench SHALL cover: rst=1 after the 3rd bit of 8'h66 -> sout=0 and state IDLE at the next edge; after release, a new load of 8'h0F serializes correctly.
